microwave_cook_controller: RTL

Top-level cook sequencer for the microwave. Takes keypad digits as a 4-digit BCD MM:SS cook time and runs a one-second prescaler counter. Counts the time down while the magnetron is enabled, and handles door, pause/resume, clear and the end-of-cook beep. Its outputs drive the display decoders and the magnetron/beeper drivers.

---
 rtl/microwave_cook_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/microwave_cook_controller.sv
// Microwave cook sequencer: BCD MM:SS keypad entry, one-second prescaler,
// countdown while heating, door/pause/clear handling and end-of-cook beep.
module microwave_cook_controller #(
  parameter int TICKS_PER_SEC  = 50000000,
  parameter int DONE_BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  output logic       magnetron_on,
  output logic       beep,
  output logic       sec_tick,
  output logic [2:0] state,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = $clog2(DONE_BEEP_SECS + 1);
  localparam logic [PW-1:0] PRE_TC    = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(DONE_BEEP_SECS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        st, st_nx;
  logic [15:0]   tm, tm_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic          tick_nx;

  // One-second BCD decrement; never called on 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, s1, s0;
    {mt, mo, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, s1, s0};
  endfunction

  always_comb begin
    st_nx   = st;
    tm_nx   = tm;
    pre_nx  = pre;
    bcnt_nx = bcnt;
    tick_nx = 1'b0;
    case (st)
      S_IDLE: begin
        if (!stop_clear && !door_open && !start && key_valid && key_digit <= 4'd9) begin
          tm_nx = {tm[11:0], key_digit};
          st_nx = S_SET;
        end
      end
      S_SET: begin
        if (stop_clear) begin
          tm_nx = 16'h0000;
          st_nx = S_IDLE;
        end else if (door_open) begin
          st_nx = S_SET;
        end else if (start) begin
          if (tm != 16'h0000) begin
            st_nx  = S_COOK;
            pre_nx = '0;
            if (tm[7:4] > 4'd5) tm_nx[7:0] = 8'h59;
          end
        end else if (key_valid && key_digit <= 4'd9) begin
          tm_nx = {tm[11:0], key_digit};
        end
      end
      S_COOK: begin
        // Pausing freezes the prescaler, even on its terminal count.
        if (stop_clear || door_open) begin
          st_nx = S_PAUSE;
        end else if (pre == PRE_TC) begin
          pre_nx  = '0;
          tick_nx = 1'b1;
          tm_nx   = bcd_dec(tm);
          if (tm_nx == 16'h0000) begin
            st_nx   = S_DONE;
            bcnt_nx = '0;
          end
        end else begin
          pre_nx = pre + 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          tm_nx  = 16'h0000;
          pre_nx = '0;
          st_nx  = S_IDLE;
        end else if (!door_open && start) begin
          st_nx = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_clear || door_open) begin
          pre_nx = '0;
          st_nx  = S_IDLE;
        end else if (pre == PRE_TC) begin
          pre_nx = '0;
          if (bcnt == BEEP_LAST) st_nx = S_IDLE;
          else bcnt_nx = bcnt + 1'b1;
        end else begin
          pre_nx = pre + 1'b1;
        end
      end
      default: begin
        st_nx  = S_IDLE;
        tm_nx  = 16'h0000;
        pre_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      tm           <= 16'h0000;
      pre          <= '0;
      bcnt         <= '0;
      magnetron_on <= 1'b0;
      beep         <= 1'b0;
      sec_tick     <= 1'b0;
    end else begin
      st           <= st_nx;
      tm           <= tm_nx;
      pre          <= pre_nx;
      bcnt         <= bcnt_nx;
      magnetron_on <= (st_nx == S_COOK);
      beep         <= (st_nx == S_DONE);
      sec_tick     <= tick_nx;
    end
  end

  assign state    = st;
  assign min_tens = tm[15:12];
  assign min_ones = tm[11:8];
  assign sec_tens = tm[7:4];
  assign sec_ones = tm[3:0];

endmodule
